sram_b_burst_reader: RTL

- Read-side client for the 1w:1r banked SRAM wrappers.
- Accepts a burst request (start address, word count) and issues back-to-back reads on the read port (CE1/A1).
- Captures Q1 one cycle after each read and presents the data as a valid/ready stream with a last flag.
- Sustains one word per cycle under no backpressure and never drops or duplicates data under backpressure.

---
 rtl/sram_b_burst_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/sram_b_burst_reader.sv
// sram_b_burst_reader: burst read client for the 1w:1r banked SRAM read port
//   req_valid/req_ready/req_addr/req_len : burst request (len = words-1)
//   CE1/A1/Q1                            : SRAM read port, Q1 valid one cycle after CE1
//   out_valid/out_ready/out_data/out_last: output stream
//   busy                                 : burst in progress
//   wrap_err (SRAM_B_BURST_READER_WRAP_CHECK_EN only): one-cycle pulse after
//   accepting a burst whose address range crosses 2^ABITS-1
module sram_b_burst_reader #(
  parameter int ABITS = 17,
  parameter int DBITS = 8,
  parameter int LBITS = 17
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [LBITS-1:0] req_len,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef SRAM_B_BURST_READER_WRAP_CHECK_EN
  ,
  output logic             wrap_err
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ABITS-1:0] addr_q;
  logic [LBITS-1:0] rem_q;
  logic if_q, if_last_q;
  logic [DBITS:0] mem_q [2];
  logic wp_q, rp_q;
  logic [1:0] cnt_q, cnt_d;
  logic pop, accept, credit, fin;
  assign pop    = out_valid & out_ready;
  assign accept = req_ready & req_valid;
  // every issued read must find a FIFO slot when its Q1 arrives
  assign credit = (cnt_q + 2'(if_q)) < (2'd2 + 2'(pop));
  assign fin    = CE1 && rem_q == '0;
  assign cnt_d  = cnt_q + 2'(if_q) - 2'(pop);
  always_ff @(posedge CLK) state_q <= RST ? IDLE : state_d;
  always_comb begin
    state_d = (state_q == IDLE && req_valid) ? ISSUE :
              (state_q == ISSUE && fin) ? DRAIN :
              (state_q == DRAIN && cnt_d == 2'd0 && !if_q) ? IDLE : state_q;
  end
  always_comb begin
    req_ready = state_q == IDLE;
    CE1       = state_q == ISSUE && credit;
    A1        = addr_q;
    busy      = state_q != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      rem_q     <= '0;
      if_q      <= 1'b0;
      if_last_q <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        rem_q  <= req_len;
      end else if (CE1) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= fin ? rem_q : rem_q - 1'b1;
      end
      if_q      <= CE1;
      if_last_q <= fin;
      if (if_q) begin
        mem_q[wp_q] <= {if_last_q, Q1};
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = mem_q[rp_q][DBITS-1:0];
  assign out_last  = out_valid & mem_q[rp_q][DBITS];
`ifdef SRAM_B_BURST_READER_WRAP_CHECK_EN
  localparam int SW = (ABITS > LBITS ? ABITS : LBITS) + 1;
  logic [SW-1:0] sum;
  logic wrap_q;
  assign sum = SW'(req_addr) + SW'(req_len);
  always_ff @(posedge CLK) wrap_q <= !RST && accept && (sum >> ABITS) != '0;
  assign wrap_err = wrap_q;
`endif
endmodule
